// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states, default sizes.
package alu_pkg;

    localparam int W_DEF    = 16;
    localparam int NREG_DEF = 4;

    localparam logic [2:0] OPC_NEG    = 3'd0;
    localparam logic [2:0] OPC_INC    = 3'd1;
    localparam logic [2:0] OPC_ADD    = 3'd2;
    localparam logic [2:0] OPC_ADDSHR = 3'd3;
    localparam logic [2:0] OPC_AND    = 3'd4;
    localparam logic [2:0] OPC_OR     = 3'd5;
    localparam logic [2:0] OPC_PACK   = 3'd6;
    localparam logic [2:0] OPC_LDI    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// General register file: two async operand reads, one async debug read, one sync write port.
module alu_regfile #(
    parameter int NREG = 4,
    parameter int W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(NREG)-1:0]  waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(NREG)-1:0]  raddr_a_i,
    input  logic [$clog2(NREG)-1:0]  raddr_b_i,
    input  logic [$clog2(NREG)-1:0]  raddr_d_i,
    output logic [W-1:0]             rdata_a_o,
    output logic [W-1:0]             rdata_b_o,
    output logic [W-1:0]             rdata_d_o
);

    logic [W-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
    assign rdata_d_o = mem_q[raddr_d_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of an external combinational ALU: operand fetch, execute, writeback.
// Load-immediate (opcode 7) bypasses the ALU and leaves the flags untouched.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opc,
    input  logic [$clog2(NREG)-1:0]  cmd_dst,
    input  logic [$clog2(NREG)-1:0]  cmd_srca,
    input  logic [$clog2(NREG)-1:0]  cmd_srcb,
    input  logic                     cmd_cin,
    input  logic [W-1:0]             cmd_imm,
    output logic                     done,
    output logic [W-1:0]             alu_ina,
    output logic [W-1:0]             alu_inb,
    output logic                     alu_inc,
    output logic [2:0]               alu_opc,
    input  logic [W-1:0]             alu_outw,
    input  logic                     alu_zer,
    input  logic                     alu_neg,
    output logic                     zer_flag,
    output logic                     neg_flag,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    output logic [W-1:0]             rd_data
);

    localparam int AW = $clog2(NREG);

    state_t          state_q;
    logic [W-1:0]    alu_ina_q;
    logic [W-1:0]    alu_inb_q;
    logic            alu_inc_q;
    logic [2:0]      alu_opc_q;
    logic [W-1:0]    res_q;
    logic            zer_lat_q;
    logic            neg_lat_q;
    logic            zer_flag_q;
    logic            neg_flag_q;
    logic [AW-1:0]   dst_q;
    logic            is_ld_q;

    logic [W-1:0]    rdata_a;
    logic [W-1:0]    rdata_b;

    // Operands are read straight off the command source indices so they are valid at accept.
    alu_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (state_q == S_WB),
        .waddr_i   (dst_q),
        .wdata_i   (res_q),
        .raddr_a_i (cmd_srca),
        .raddr_b_i (cmd_srcb),
        .raddr_d_i (rd_addr),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .rdata_d_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            alu_ina_q  <= '0;
            alu_inb_q  <= '0;
            alu_inc_q  <= 1'b0;
            alu_opc_q  <= '0;
            res_q      <= '0;
            zer_lat_q  <= 1'b0;
            neg_lat_q  <= 1'b0;
            zer_flag_q <= 1'b0;
            neg_flag_q <= 1'b0;
            dst_q      <= '0;
            is_ld_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dst_q <= cmd_dst;
                        if (cmd_opc == OPC_LDI) begin
                            res_q   <= cmd_imm;
                            is_ld_q <= 1'b1;
                            state_q <= S_WB;
                        end else begin
                            alu_ina_q <= rdata_a;
                            alu_inb_q <= rdata_b;
                            alu_opc_q <= cmd_opc;
                            alu_inc_q <= (cmd_opc == OPC_ADD) & cmd_cin;
                            is_ld_q   <= 1'b0;
                            state_q   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    res_q     <= alu_outw;
                    zer_lat_q <= alu_zer;
                    neg_lat_q <= alu_neg;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    if (!is_ld_q) begin
                        zer_flag_q <= zer_lat_q;
                        neg_flag_q <= neg_lat_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_WB);
    assign alu_ina   = alu_ina_q;
    assign alu_inb   = alu_inb_q;
    assign alu_inc   = alu_inc_q;
    assign alu_opc   = alu_opc_q;
    assign zer_flag  = zer_flag_q;
    assign neg_flag  = neg_flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural stand-in for the external ALU.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opc = '0;
    logic [1:0]  cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
    logic        cmd_cin = 1'b0;
    logic [15:0] cmd_imm = '0;
    logic        done;
    logic [15:0] alu_ina, alu_inb, alu_outw;
    logic        alu_inc, alu_zer, alu_neg;
    logic [2:0]  alu_opc;
    logic        zer_flag, neg_flag;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    logic        dbg_sel = 1'b0;
    logic [1:0]  dbg_addr = '0;
    logic [1:0]  mon_addr = '0;
    assign rd_addr = dbg_sel ? dbg_addr : mon_addr;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_cin(cmd_cin), .cmd_imm(cmd_imm), .done(done),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc), .alu_opc(alu_opc),
        .alu_outw(alu_outw), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .zer_flag(zer_flag), .neg_flag(neg_flag),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // External combinational ALU stand-in
    always_comb begin
        alu_outw = 16'h0000;
        case (alu_opc)
            3'd0: alu_outw = -alu_ina;
            3'd1: alu_outw = alu_ina + 16'd1;
            3'd2: alu_outw = alu_ina + alu_inb + {15'd0, alu_inc};
            3'd3: alu_outw = alu_ina + {alu_inb[15], alu_inb[15:1]};
            3'd4: alu_outw = alu_ina & alu_inb;
            3'd5: alu_outw = alu_ina | alu_inb;
            3'd6: alu_outw = {alu_ina[7:0], alu_inb[7:0]};
            default: alu_outw = 16'h0000;
        endcase
    end
    assign alu_zer = (alu_outw == 16'h0000);
    assign alu_neg = alu_outw[15];

    typedef struct {
        logic [1:0]  dst;
        logic [15:0] val;
        logic        z;
        logic        n;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int n_acc = 0, n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse, then checks writeback one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                chk("ready_in_wb", {31'd0, cmd_ready}, 32'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc - e.acc + 1, e.lat);
                    mon_addr = e.dst;
                    @(negedge clk);
                    chk("rd_data", {16'd0, rd_data}, {16'd0, e.val});
                    chk("zer_flag", {31'd0, zer_flag}, {31'd0, e.z});
                    chk("neg_flag", {31'd0, neg_flag}, {31'd0, e.n});
                end
            end
        end
    end

    task automatic issue(input logic [2:0] opc, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic cin, input logic [15:0] imm,
                         input logic [15:0] ev, input logic ez, input logic en,
                         input bit push, input bit hold);
        int   n = 0;
        exp_t e;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
            cmd_valid = 1'b0;
            return;
        end
        cmd_opc = opc; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_cin = cin; cmd_imm = imm; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.dst = dst; e.val = ev; e.z = ez; e.n = en;
            e.lat = (opc == OPC_LDI) ? 1 : 2;
            e.acc = cyc;
            sbq.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        if (opc != OPC_LDI) begin
            chk("ready_exec", {31'd0, cmd_ready}, 32'd0);
            chk("alu_opc", {29'd0, alu_opc}, {29'd0, opc});
            chk("alu_inc", {31'd0, alu_inc}, {31'd0, (opc == OPC_ADD) & cin});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_zer", {31'd0, zer_flag}, 32'd0);
        chk("rst_neg", {31'd0, neg_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Dirty some state, then reset in the middle of an ALU command
        issue(OPC_LDI, 2'd0, 2'd0, 2'd0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1, 0);
        issue(OPC_NEG, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1, 1, 0);
        issue(OPC_AND, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dbg_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = i[1:0];
            #1;
            chk("midrst_reg", {16'd0, rd_data}, 32'd0);
        end
        chk("midrst_zer", {31'd0, zer_flag}, 32'd0);
        chk("midrst_neg", {31'd0, neg_flag}, 32'd0);
        chk("midrst_ina", {16'd0, alu_ina}, 32'd0);
        chk("midrst_opc", {29'd0, alu_opc}, 32'd0);
        dbg_sel = 1'b0;
        repeat (4) @(negedge clk);

        // Negate
        issue(OPC_LDI, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0, 1, 0);
        issue(OPC_NEG, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0000, 16'hFFFB, 1'b0, 1'b1, 1, 0);
        // Add with carry, signed overflow into bit 15
        issue(OPC_LDI, 2'd2, 2'd0, 2'd0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1, 0);
        issue(OPC_LDI, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1, 1, 0);
        issue(OPC_ADD, 2'd2, 2'd2, 2'd3, 1'b1, 16'h0000, 16'h8001, 1'b0, 1'b1, 1, 0);
        // AND to zero, then a load must not touch the flags
        issue(OPC_LDI, 2'd0, 2'd0, 2'd0, 1'b0, 16'h00F0, 16'h00F0, 1'b0, 1'b1, 1, 0);
        issue(OPC_LDI, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1, 0);
        issue(OPC_AND, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 0);
        issue(OPC_LDI, 2'd3, 2'd0, 2'd0, 1'b0, 16'h1234, 16'h1234, 1'b1, 1'b0, 1, 0);
        // cmd_valid held high across a stream of commands
        issue(OPC_LDI,  2'd0, 2'd0, 2'd0, 1'b0, 16'h12AB, 16'h12AB, 1'b1, 1'b0, 1, 1);
        issue(OPC_LDI,  2'd1, 2'd0, 2'd0, 1'b0, 16'h34CD, 16'h34CD, 1'b1, 1'b0, 1, 1);
        issue(OPC_PACK, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'hABCD, 1'b0, 1'b1, 1, 1);
        issue(OPC_INC,  2'd3, 2'd2, 2'd0, 1'b1, 16'h0000, 16'hABCE, 1'b0, 1'b1, 1, 1);
        issue(OPC_PACK, 2'd0, 2'd1, 2'd0, 1'b0, 16'h0000, 16'hCDAB, 1'b0, 1'b1, 1, 1);
        issue(OPC_INC,  2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'hCDAC, 1'b0, 1'b1, 1, 1);
        cmd_valid = 1'b0;
        // Add with arithmetic-shifted B
        issue(OPC_LDI,    2'd0, 2'd0, 2'd0, 1'b0, 16'h0010, 16'h0010, 1'b0, 1'b1, 1, 0);
        issue(OPC_LDI,    2'd1, 2'd0, 2'd0, 1'b0, 16'hFFFC, 16'hFFFC, 1'b0, 1'b1, 1, 0);
        issue(OPC_ADDSHR, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h000E, 1'b0, 1'b0, 1, 0);
        // OR, increment wrap, add without carry
        issue(OPC_OR,  2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'hFFFC, 1'b0, 1'b1, 1, 0);
        issue(OPC_LDI, 2'd0, 2'd0, 2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1, 0);
        issue(OPC_INC, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 0);
        issue(OPC_ADD, 2'd1, 2'd2, 2'd2, 1'b0, 16'h0000, 16'h001C, 1'b0, 1'b0, 1, 0);

        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", sbq.size(), 32'd0);
        chk("done_count", n_done, n_acc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
